usb_tx_sequencer: RTL and testbench

USB_TX_SEQUENCER -- requirements
Module: usb_tx_sequencer

---
 rtl/usb_tx_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 tb/tb_usb_tx_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_sequencer.sv
// -----------------------------------------------------------------------------
// usb_tx_sequencer
//
// Purpose:
//   Sequences the bytes of one USB packet towards a bit serialiser:
//   SYNC (0x80), PID, optional payload, optional CRC16 (two bytes,
//   inverted, low byte first), then hands off to the line driver for the
//   end-of-packet.  Handshake packets (ACK/NAK/STALL) carry only SYNC+PID.
//
// Configuration:
//   USB_TX_INT_CRC_EN  defined   : CRC16 (poly 0x8005, init 0xFFFF,
//                                  LSB-first) is computed inside this block
//                                  over the transferred payload bytes and
//                                  crc_in is ignored.
//                      undefined : CRC bytes come from the external
//                                  generator on crc_in.
//   crc_clear / crc_en are driven in both builds.
//
// Parameters:
//   MAX_PAYLOAD  largest legal payload byte count (1..1023)
//   SIZE_W       width of the size/count fields, 2**SIZE_W > MAX_PAYLOAD
//
// Ports:
//   clk                  system clock (single clock domain)
//   n_rst                asynchronous active-low reset
//   tx_start             one-cycle request, only looked at while idle
//   tx_packet            packet type: 1 DATA0, 2 DATA1, 3 ACK, 4 NAK, 5 STALL
//   tx_packet_data_size  payload byte count (data packets only)
//   tx_packet_data       payload byte from a first-word-fall-through source
//   get_tx_packet_data   pop strobe to the payload source
//   tx_abort             terminate the packet currently being sent
//   byte_out/byte_valid  byte offered to the serialiser
//   byte_ready           serialiser takes byte_out this cycle
//   crc_in               running CRC16 from an external generator
//   crc_clear/crc_en     external CRC generator controls
//   eop_req/eop_done     end-of-packet request / one-cycle completion pulse
//   busy                 a packet is in progress
//   tx_done/tx_error     one-cycle completion / error pulses
// -----------------------------------------------------------------------------
module usb_tx_sequencer #(
  parameter int MAX_PAYLOAD = 64,
  parameter int SIZE_W      = 7
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              tx_start,
  input  logic [2:0]        tx_packet,
  input  logic [SIZE_W-1:0] tx_packet_data_size,
  input  logic [7:0]        tx_packet_data,
  output logic              get_tx_packet_data,
  input  logic              tx_abort,
  output logic [7:0]        byte_out,
  output logic              byte_valid,
  input  logic              byte_ready,
  input  logic [15:0]       crc_in,
  output logic              crc_clear,
  output logic              crc_en,
  output logic              eop_req,
  input  logic              eop_done,
  output logic              busy,
  output logic              tx_done,
  output logic              tx_error
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SYNC   = 3'd1;
  localparam logic [2:0] ST_PID    = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_CRC_LO = 3'd4;
  localparam logic [2:0] ST_CRC_HI = 3'd5;
  localparam logic [2:0] ST_EOP    = 3'd6;

  localparam logic [2:0] PKT_DATA0 = 3'd1;
  localparam logic [2:0] PKT_DATA1 = 3'd2;
  localparam logic [2:0] PKT_ACK   = 3'd3;
  localparam logic [2:0] PKT_NAK   = 3'd4;
  localparam logic [2:0] PKT_STALL = 3'd5;

  localparam logic [7:0] SYNC_BYTE = 8'h80;

  // One extra bit so the comparison is safe for any legal parameter pair.
  localparam logic [SIZE_W:0] MAX_SIZE = (SIZE_W + 1)'(MAX_PAYLOAD);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [2:0]        state_reg;
  logic [2:0]        state_next;
  logic [2:0]        type_reg;
  logic [SIZE_W-1:0] remain_reg;
  logic [15:0]       crc_hold_reg;
  logic              crc_held_reg;
  logic              tx_done_reg;
  logic              tx_error_reg;

  // ---------------------------------------------------------------------------
  // Request qualification (only meaningful while idle)
  // ---------------------------------------------------------------------------
  logic start_type_legal;
  logic start_is_data;
  logic start_size_legal;
  logic start_ok;
  logic start_bad;

  assign start_type_legal = (tx_packet >= PKT_DATA0) && (tx_packet <= PKT_STALL);
  assign start_is_data    = (tx_packet == PKT_DATA0) || (tx_packet == PKT_DATA1);
  assign start_size_legal = !start_is_data || ({1'b0, tx_packet_data_size} <= MAX_SIZE);

  assign start_ok  = (state_reg == ST_IDLE) && tx_start && start_type_legal && start_size_legal;
  assign start_bad = (state_reg == ST_IDLE) && tx_start && !(start_type_legal && start_size_legal);

  // ---------------------------------------------------------------------------
  // Byte handshake
  // ---------------------------------------------------------------------------
  logic in_byte_state;
  logic abort_hit;
  logic xfer;
  logic is_data_type;
  logic last_byte;

  assign in_byte_state = (state_reg == ST_SYNC) || (state_reg == ST_PID) ||
                         (state_reg == ST_DATA) || (state_reg == ST_CRC_LO) ||
                         (state_reg == ST_CRC_HI);

  // An abort withdraws the byte in the same cycle, so an abort can never
  // coincide with a transfer (and therefore never with a pop).
  assign abort_hit = in_byte_state && tx_abort;
  assign xfer      = in_byte_state && !tx_abort && byte_ready;

  assign is_data_type = (type_reg == PKT_DATA0) || (type_reg == PKT_DATA1);
  assign last_byte    = (remain_reg == SIZE_W'(1));

  // ---------------------------------------------------------------------------
  // CRC source
  // ---------------------------------------------------------------------------
  logic [15:0] crc_src;

`ifdef USB_TX_INT_CRC_EN
  logic [15:0] crc_int_reg;
  logic        unused_crc_in;

  // Reflected form of poly 0x8005 (0xA001), one payload byte LSB-first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc_cur,
                                             input logic [7:0]  data);
    logic [15:0] c;
    c = crc_cur;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) begin
        c = (c >> 1) ^ 16'hA001;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      crc_int_reg <= 16'hFFFF;
    end else if (crc_clear) begin
      crc_int_reg <= 16'hFFFF;
    end else if (crc_en) begin
      crc_int_reg <= crc16_byte(crc_int_reg, tx_packet_data);
    end
  end

  assign crc_src       = crc_int_reg;
  assign unused_crc_in = ^crc_in;
`else
  assign crc_src = crc_in;
`endif

  // The external generator folds in the last payload byte on the clock edge
  // that enters CRC_LO, so the final CRC is only visible during the first
  // CRC_LO cycle.  It is shown straight through in that cycle and held in
  // crc_hold_reg from then on, keeping byte_out stable through stalls.
  logic [15:0] crc_final;
  assign crc_final = ((state_reg == ST_CRC_LO) && !crc_held_reg) ? crc_src : crc_hold_reg;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start_ok) begin
          state_next = ST_SYNC;
        end
      end
      ST_SYNC: begin
        if (abort_hit) begin
          state_next = ST_EOP;
        end else if (xfer) begin
          state_next = ST_PID;
        end
      end
      ST_PID: begin
        if (abort_hit) begin
          state_next = ST_EOP;
        end else if (xfer) begin
          if (!is_data_type) begin
            state_next = ST_EOP;
          end else if (remain_reg != '0) begin
            state_next = ST_DATA;
          end else begin
            state_next = ST_CRC_LO;
          end
        end
      end
      ST_DATA: begin
        if (abort_hit) begin
          state_next = ST_EOP;
        end else if (xfer && last_byte) begin
          state_next = ST_CRC_LO;
        end
      end
      ST_CRC_LO: begin
        if (abort_hit) begin
          state_next = ST_EOP;
        end else if (xfer) begin
          state_next = ST_CRC_HI;
        end
      end
      ST_CRC_HI: begin
        if (abort_hit) begin
          state_next = ST_EOP;
        end else if (xfer) begin
          state_next = ST_EOP;
        end
      end
      ST_EOP: begin
        if (eop_done) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg    <= ST_IDLE;
      type_reg     <= 3'd0;
      remain_reg   <= '0;
      crc_hold_reg <= 16'h0000;
      crc_held_reg <= 1'b0;
      tx_done_reg  <= 1'b0;
      tx_error_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      tx_done_reg  <= (state_reg == ST_EOP) && eop_done;
      tx_error_reg <= start_bad || abort_hit;

      // Handshake packets ignore the size field, so they latch zero.
      if (start_ok) begin
        type_reg   <= tx_packet;
        remain_reg <= start_is_data ? tx_packet_data_size : '0;
      end else if ((state_reg == ST_DATA) && xfer) begin
        remain_reg <= remain_reg - SIZE_W'(1);
      end

      if (state_reg != ST_CRC_LO) begin
        crc_held_reg <= 1'b0;
      end else if (!crc_held_reg) begin
        crc_hold_reg <= crc_src;
        crc_held_reg <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Byte multiplexer
  // ---------------------------------------------------------------------------
  logic [7:0] pid_byte;

  always_comb begin
    pid_byte = 8'h00;
    case (type_reg)
      PKT_DATA0: pid_byte = 8'hC3;
      PKT_DATA1: pid_byte = 8'h4B;
      PKT_ACK:   pid_byte = 8'hD2;
      PKT_NAK:   pid_byte = 8'h5A;
      PKT_STALL: pid_byte = 8'h1E;
      default:   pid_byte = 8'h00;
    endcase
  end

  always_comb begin
    byte_out = 8'h00;
    case (state_reg)
      ST_SYNC:   byte_out = SYNC_BYTE;
      ST_PID:    byte_out = pid_byte;
      ST_DATA:   byte_out = tx_packet_data;
      ST_CRC_LO: byte_out = ~crc_final[7:0];
      ST_CRC_HI: byte_out = ~crc_final[15:8];
      default:   byte_out = 8'h00;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign byte_valid         = in_byte_state && !tx_abort;
  assign get_tx_packet_data = (state_reg == ST_DATA) && xfer;
  assign crc_en             = (state_reg == ST_DATA) && xfer;
  assign crc_clear          = start_ok;
  assign eop_req            = (state_reg == ST_EOP);
  assign busy               = (state_reg != ST_IDLE);
  assign tx_done            = tx_done_reg;
  assign tx_error           = tx_error_reg;

endmodule

// File: tb/tb_usb_tx_sequencer.sv
// -----------------------------------------------------------------------------
// tb_usb_tx_sequencer
//
// Drives packet requests into usb_tx_sequencer together with a payload FIFO,
// an external CRC16 generator and an EOP responder, and compares the byte
// stream, pop count and status pulses with a packet-level reference model.
// -----------------------------------------------------------------------------
module tb_usb_tx_sequencer;

  localparam int MAX_PAYLOAD = 64;
  localparam int SIZE_W      = 7;

  logic              clk = 1'b0;
  logic              n_rst;
  logic              tx_start;
  logic [2:0]        tx_packet;
  logic [SIZE_W-1:0] tx_packet_data_size;
  logic [7:0]        tx_packet_data;
  logic              get_tx_packet_data;
  logic              tx_abort;
  logic [7:0]        byte_out;
  logic              byte_valid;
  logic              byte_ready;
  logic [15:0]       crc_in;
  logic              crc_clear;
  logic              crc_en;
  logic              eop_req;
  logic              eop_done;
  logic              busy;
  logic              tx_done;
  logic              tx_error;

  always #5 clk = ~clk;

  usb_tx_sequencer #(
    .MAX_PAYLOAD(MAX_PAYLOAD),
    .SIZE_W     (SIZE_W)
  ) dut (
    .clk                (clk),
    .n_rst              (n_rst),
    .tx_start           (tx_start),
    .tx_packet          (tx_packet),
    .tx_packet_data_size(tx_packet_data_size),
    .tx_packet_data     (tx_packet_data),
    .get_tx_packet_data (get_tx_packet_data),
    .tx_abort           (tx_abort),
    .byte_out           (byte_out),
    .byte_valid         (byte_valid),
    .byte_ready         (byte_ready),
    .crc_in             (crc_in),
    .crc_clear          (crc_clear),
    .crc_en             (crc_en),
    .eop_req            (eop_req),
    .eop_done           (eop_done),
    .busy               (busy),
    .tx_done            (tx_done),
    .tx_error           (tx_error)
  );

  // Payload source: first-word-fall-through over a circular buffer.
  logic [7:0]  pay_mem [0:4095];
  logic [11:0] pay_rd = '0;
  assign tx_packet_data = pay_mem[pay_rd];

  int errors = 0;
  int checks = 0;

  // Environment / observation state
  int          rdy_pct, abort_pop, stall_pop, st_left, eop_cnt;
  bit          ab_done, st_done, noise, last_abort, ab_checked, ab_ok;
  bit          prev_valid, prev_xfer;
  logic [7:0]  prev_byte;
  int          pops, err_n, busy_n, viol, stall_bad;
  logic [7:0]  cap_q [$];
  logic [15:0] crc_m = 16'h0000;
  logic [7:0]  preset [0:3];

  typedef struct {
    string name;
    int    ty;
    int    sz;
    int    rdy;
    int    exp_err;
    int    exp_len;
  } vec_t;
  vec_t tbl [12];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // CRC16-USB: poly x^16+x^15+x^2+1, processed LSB-first (reflected 0xA001).
  function automatic logic [15:0] crc_upd(input logic [15:0] c_in, input logic [7:0] d);
    logic [15:0] c;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      c = ((c[0] ^ d[i]) != 1'b0) ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  function automatic logic [7:0] pid_of(input int ty);
    case (ty)
      1: return 8'hC3;
      2: return 8'h4B;
      3: return 8'hD2;
      4: return 8'h5A;
      default: return 8'h1E;
    endcase
  endfunction

  // One clock: observe at the falling edge, then drive just after the
  // rising edge.
  task automatic tick();
    logic       s_get, s_clr, s_en;
    logic [7:0] s_data;
    @(negedge clk);
    s_get  = get_tx_packet_data;
    s_clr  = crc_clear;
    s_en   = crc_en;
    s_data = tx_packet_data;
    if (byte_valid && byte_ready) cap_q.push_back(byte_out);
    if (prev_valid && !prev_xfer && byte_valid && (byte_out != prev_byte)) stall_bad++;
    prev_valid = byte_valid;
    prev_xfer  = byte_valid && byte_ready;
    prev_byte  = byte_out;
    if (s_get) begin
      pops++;
      if (!byte_ready) viol++;
    end
    if (tx_error) err_n++;
    if (busy) busy_n++;
    if (last_abort) begin
      ab_checked = 1'b1;
      ab_ok      = eop_req && tx_error && !byte_valid;
    end
    last_abort = tx_abort;
    eop_cnt = eop_req ? eop_cnt + 1 : 0;

    @(posedge clk);
    #1;
    if (s_get) pay_rd = pay_rd + 12'd1;
    if (s_clr) crc_m = 16'hFFFF;
    else if (s_en) crc_m = crc_upd(crc_m, s_data);
    crc_in   = crc_m;
    tx_start = 1'b0;
    tx_abort = 1'b0;
    eop_done = (eop_cnt == 2);
    if (st_left > 0) begin
      byte_ready = 1'b0;
      st_left--;
    end else if (stall_pop >= 0 && !st_done && pops == stall_pop) begin
      byte_ready = 1'b0;
      st_left    = 2;
      st_done    = 1'b1;
    end else begin
      byte_ready = ($urandom_range(0, 99) < rdy_pct);
    end
    if (abort_pop >= 0 && !ab_done && pops == abort_pop && busy) begin
      tx_abort   = 1'b1;
      byte_ready = 1'b1;
      ab_done    = 1'b1;
    end
    if (noise && busy && $urandom_range(0, 3) == 0) begin
      tx_start            = 1'b1;
      tx_packet           = 3'($urandom);
      tx_packet_data_size = SIZE_W'($urandom);
    end
  endtask

  // Request one packet and follow it to completion; called in the drive
  // phase, returns in the drive phase of the cycle where tx_done is high.
  task automatic run_pkt(input string name, input int ty, input int sz, input int rp,
                         input int ab, input int sp, input bit use_preset,
                         output int act_err, output int act_len);
    int          base, n, bad, exp_pops;
    bit          legal, exp_err, got_done;
    logic [7:0]  b;
    logic [15:0] c;
    logic [7:0]  exp_q [$];

    base = int'(pay_rd);
    for (int i = 0; i < sz; i++) begin
      pay_mem[12'(base + i)] = use_preset ? preset[i % 4] : 8'($urandom);
    end
    rdy_pct = rp; abort_pop = ab; ab_done = 1'b0; stall_pop = sp; st_done = 1'b0;
    st_left = 0; pops = 0; err_n = 0; busy_n = 0; viol = 0; stall_bad = 0;
    ab_checked = 1'b0; ab_ok = 1'b0;
    cap_q.delete();

    // Reference: byte list straight from the packet format.
    exp_q.delete();
    legal = (ty >= 1 && ty <= 5) && (ty >= 3 || sz <= MAX_PAYLOAD);
    n = 0;
    if (legal) begin
      exp_q.push_back(8'h80);
      exp_q.push_back(pid_of(ty));
      if (ty <= 2) begin
        n = (ab >= 0) ? ab : sz;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
          b = pay_mem[12'(base + i)];
          exp_q.push_back(b);
          c = crc_upd(c, b);
        end
        if (ab < 0) begin
          exp_q.push_back(~c[7:0]);
          exp_q.push_back(~c[15:8]);
        end
      end
    end
    exp_err  = !legal || (ab >= 0);
    exp_pops = n;

    tx_start            = 1'b1;
    tx_packet           = 3'(ty);
    tx_packet_data_size = SIZE_W'(sz);

    got_done = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      if (tx_done) begin
        got_done = 1'b1;
        break;
      end
      if (!legal && cyc >= 3) break;
    end

    bad = -1;
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
      if (bad < 0 && cap_q[i] != exp_q[i]) bad = i;
    end
    check({name, " stream_len"}, cap_q.size(), exp_q.size());
    check({name, " first_bad_byte_index"}, bad, -1);
    check({name, " pops"}, pops, exp_pops);
    check({name, " tx_done"}, int'(got_done), int'(legal));
    check({name, " tx_error_pulses"}, err_n, int'(exp_err));
    check({name, " pop_without_ready"}, viol, 0);
    check({name, " unstable_during_stall"}, stall_bad, 0);
    if (!legal) check({name, " busy_cycles"}, busy_n, 0);
    if (ab >= 0) check({name, " abort_to_eop_next_cycle"}, int'(ab_checked && ab_ok), 1);

    act_err = err_n;
    act_len = cap_q.size();
    $display("pkt %-10s type=%0d size=%0d bytes=%0d pops=%0d done=%0d err=%0d",
             name, ty, sz, cap_q.size(), pops, got_done, err_n);
  endtask

  function automatic int out_vec();
    return int'({byte_out, byte_valid, get_tx_packet_data, crc_clear, crc_en,
                 eop_req, busy, tx_done, tx_error});
  endfunction

  initial begin
    int ae, al, r, ty, sz;

    tbl[0]  = '{"ack",     3,   0, 100, 0, 2};
    tbl[1]  = '{"nak",     4,   9, 100, 0, 2};
    tbl[2]  = '{"stall",   5,   0,  60, 0, 2};
    tbl[3]  = '{"zlp",     1,   0, 100, 0, 4};
    tbl[4]  = '{"d1s4",    2,   4, 100, 0, 8};
    tbl[5]  = '{"d0max",   1,  64,  70, 0, 68};
    tbl[6]  = '{"over",    1,  65, 100, 1, 0};
    tbl[7]  = '{"type0",   0,   0, 100, 1, 0};
    tbl[8]  = '{"type6",   6,   3, 100, 1, 0};
    tbl[9]  = '{"type7",   7,   0, 100, 1, 0};
    tbl[10] = '{"d1s127",  2, 127, 100, 1, 0};
    tbl[11] = '{"d0s1",    1,   1,  50, 0, 5};

    preset[0] = 8'h11; preset[1] = 8'h22; preset[2] = 8'h33; preset[3] = 8'h44;
    for (int i = 0; i < 4096; i++) pay_mem[i] = 8'h00;

    n_rst = 1'b0; tx_start = 1'b0; tx_packet = 3'd0; tx_packet_data_size = '0;
    tx_abort = 1'b0; byte_ready = 1'b1; crc_in = 16'h0000; eop_done = 1'b0;
    rdy_pct = 100; abort_pop = -1; stall_pop = -1; st_left = 0; eop_cnt = 0;
    noise = 1'b0; last_abort = 1'b0; prev_valid = 1'b0; prev_xfer = 1'b0; prev_byte = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", out_vec(), 0);
    @(posedge clk); #1;
    n_rst = 1'b1;
    @(negedge clk);
    check("idle_after_release_busy", int'(busy), 0);
    @(posedge clk); #1;

    // Table of single requests
    for (int i = 0; i < 12; i++) begin
      run_pkt(tbl[i].name, tbl[i].ty, tbl[i].sz, tbl[i].rdy, -1, -1, 1'b0, ae, al);
      check({tbl[i].name, " tbl_err"}, ae, tbl[i].exp_err);
      check({tbl[i].name, " tbl_len"}, al, tbl[i].exp_len);
    end

    // DATA1, 4 known bytes, serialiser stalls three cycles on the third byte
    run_pkt("stall3", 2, 4, 100, -1, 2, 1'b1, ae, al);

    // Abort while the second of eight payload bytes is offered
    run_pkt("abort2nd", 1, 8, 100, 1, -1, 1'b0, ae, al);

    // Reset in the middle of the payload
    rdy_pct = 100; abort_pop = -1; stall_pop = -1; pops = 0;
    tx_start = 1'b1; tx_packet = 3'd1; tx_packet_data_size = SIZE_W'(8);
    for (int cyc = 0; cyc < 200; cyc++) begin
      tick();
      if (pops >= 2) break;
    end
    check("rst_mid_reached_data", int'(pops >= 2), 1);
    n_rst = 1'b0;
    @(negedge clk);
    check("rst_mid_outputs", out_vec(), 0);
    @(posedge clk); #1;
    n_rst = 1'b1;
    eop_cnt = 0; prev_valid = 1'b0; last_abort = 1'b0;
    @(negedge clk);
    check("rst_mid_idle_after_release", int'({busy, byte_valid, eop_req}), 0);
    $display("seq rst_mid_data pops_before_reset=%0d busy=%0d", pops, busy);
    @(posedge clk); #1;
    run_pkt("post_rst", 3, 0, 100, -1, -1, 1'b0, ae, al);

    // Randomised traffic with spurious starts while busy
    noise = 1'b1;
    for (int k = 0; k < 30; k++) begin
      r = $urandom_range(0, 9);
      if (r < 7) ty = $urandom_range(1, 5);
      else if (r == 7) ty = 0;
      else ty = $urandom_range(6, 7);
      if ($urandom_range(0, 3) == 0) sz = $urandom_range(MAX_PAYLOAD - 2, MAX_PAYLOAD + 3);
      else sz = $urandom_range(0, 12);
      run_pkt("rand", ty, sz, $urandom_range(40, 100), -1, -1, 1'b0, ae, al);
    end
    noise = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
